// File: rtl/uart_serdes.sv
// uart_serdes: 8N1 UART transmitter/receiver core clocked from an integer baud divider.
// RX samples mid-bit through a 2-flop synchronizer; TX drives a registered pin.
module uart_serdes #(
    parameter int baud_rate    = 115200,
    parameter int sys_clk_freq = 16000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       recv_error
);
    localparam int DIV  = sys_clk_freq / baud_rate;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_serdes: sys_clk_freq/baud_rate must be >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    rx_state_t     r_state, r_next;
    tx_state_t     t_state, t_next;
    logic [1:0]    rx_sync;
    logic          rx_s;
    logic [CW-1:0] r_cnt, t_cnt;
    logic [2:0]    r_bit, t_bit;
    logic [7:0]    r_shift, t_data;
    logic          r_tick_half, r_tick_full, t_tick;

    assign rx_s        = rx_sync[1];
    assign r_tick_half = (r_cnt == HALF_LAST);
    assign r_tick_full = (r_cnt == CNT_LAST);
    assign t_tick      = (t_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            t_state <= T_IDLE;
        end else begin
            r_state <= r_next;
            t_state <= t_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (!rx_s) r_next = R_START;
            R_START: if (r_tick_half) r_next = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (r_tick_full && r_bit == 3'd7) r_next = R_STOP;
            R_STOP:  if (r_tick_full) r_next = rx_s ? R_IDLE : R_WAIT;
            R_WAIT:  if (rx_s) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        t_next = t_state;
        case (t_state)
            T_IDLE:  if (transmit) t_next = T_START;
            T_START: if (t_tick) t_next = T_DATA;
            T_DATA:  if (t_tick && t_bit == 3'd7) t_next = T_STOP;
            T_STOP:  if (t_tick) t_next = T_IDLE;
            default: t_next = T_IDLE;
        endcase
    end

    always_comb begin
        is_receiving    = (r_state != R_IDLE);
        is_transmitting = (t_state != T_IDLE);
    end

    // RX datapath: the counter restarts on every state change and every full bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync    <= 2'b11;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            received   <= 1'b0;
            rx_byte    <= '0;
            recv_error <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            received <= 1'b0;
            if (r_state != r_next || r_tick_full || r_state == R_IDLE || r_state == R_WAIT)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (r_state == R_START)
                r_bit <= '0;
            if (r_state == R_DATA && r_tick_full) begin
                r_shift <= {rx_s, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_state == R_STOP && r_tick_full) begin
                if (rx_s) begin
                    rx_byte    <= r_shift;
                    received   <= 1'b1;
                    recv_error <= 1'b0;
                end else begin
                    recv_error <= 1'b1;
                end
            end
        end
    end

    // TX datapath: tx is computed one edge ahead so the pin is a plain flop
    always_ff @(posedge clk) begin
        if (rst) begin
            tx     <= 1'b1;
            t_cnt  <= '0;
            t_bit  <= '0;
            t_data <= '0;
        end else begin
            t_cnt <= (t_state == T_IDLE || t_tick) ? '0 : t_cnt + CW'(1);
            case (t_state)
                T_IDLE: begin
                    tx <= ~transmit;
                    if (transmit) t_data <= tx_byte;
                end
                T_START: begin
                    if (t_tick) begin
                        tx    <= t_data[0];
                        t_bit <= '0;
                    end
                end
                T_DATA: begin
                    if (t_tick) begin
                        t_bit <= t_bit + 3'd1;
                        if (t_bit == 3'd7) begin
                            tx <= 1'b1;
                        end else begin
                            tx     <= t_data[1];
                            t_data <= t_data >> 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/uart_serdes.md
Name: uart_serdes

Overview:
- 8N1 serial transmitter/receiver core (1 start bit, 8 data bits, no parity, 1 stop bit) that sits directly under the MC6850-style ACIA register wrapper.
- Converts between the wrapper's byte-level strobes and the rx/tx pins.
- Baud timing comes from an integer clock divider.
- Supplies the received/byte/error/busy signals that the wrapper turns into status bits and IRQs.

Parameters:
- baud_rate, 115200, serial bit rate in bits/s.
- sys_clk_freq, 16000000, clk frequency in Hz. DIV = floor(sys_clk_freq/baud_rate); HALF = floor(DIV/2). DIV >= 4 is required and checked at elaboration.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx  in  1  asynchronous serial input, idle high
- tx  out  1  serial output, registered, idle high
- transmit  in  1  one-cycle strobe: start sending tx_byte
- tx_byte  in  8  byte to send, sampled only on an accepted transmit
- received  out  1  one-cycle pulse: a valid frame was received
- rx_byte  out  8  last validly received byte
- is_receiving  out  1  high while the RX FSM is not IDLE
- is_transmitting  out  1  high while the TX FSM is not IDLE
- recv_error  out  1  sticky framing-error flag

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-high.
  - Both FSMs go to IDLE and all counters clear.
  - tx=1, received=0, rx_byte=8'h00, recv_error=0, is_receiving=0, is_transmitting=0.
  - rx synchronizer flops preset to 1.
  - An rst asserted mid-frame aborts the frame within one cycle; no partial byte or pulse is emitted.
- RX input: rx passes through a 2-flop synchronizer, giving rx_s. All RX decisions use rx_s.
- RX FSM, bit counter cnt:
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: on cnt==HALF-1, if rx_s==0 go to DATA (cnt=0, bit index 0). Otherwise go to IDLE; this is a glitch, with no error and no pulse.
  - DATA: on cnt==DIV-1, shift rx_s into the shift register LSB-first and set cnt=0. After bit 7, go to STOP.
  - STOP: on cnt==DIV-1, if rx_s==1:
    - load rx_byte from the shift register;
    - pulse received high for exactly 1 cycle;
    - clear recv_error;
    - go to IDLE.
  - STOP with rx_s==0 (framing error or break): set recv_error, leave rx_byte unchanged, no received pulse, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s==1, then go to IDLE. A held-low break therefore yields exactly one error and no spurious frames.
- RX timing:
  - Sampling occurs at the mid-point of each bit.
  - received asserts 2 + HALF + 9*DIV cycles (±1) after the falling edge of the start bit on the rx pin.
- TX FSM, divider counter plus bit index:
  - IDLE: tx=1. If transmit==1, latch tx_byte, go to START, drive tx=0 on the next edge, and raise is_transmitting on the same edge.
  - START, DATA0..7 (LSB first), STOP (tx=1) each last exactly DIV cycles. Then go to IDLE and is_transmitting falls.
  - Frame length is 10*DIV cycles from the first tx low to is_transmitting low.
  - transmit while not IDLE is ignored: no queueing, and the in-flight byte is unaffected.
  - transmit in the same cycle that STOP completes is also ignored. A new frame needs transmit with the FSM already IDLE.
- Independence: RX and TX are fully independent; simultaneous activity is legal.
- Output latching: rx_byte is stable between received pulses. recv_error is level-held until the next good frame or rst.

Test Plan (sys_clk_freq=16000000, baud_rate=1000000, so DIV=16, HALF=8, unless noted):
- TX frame: after reset, transmit pulse with tx_byte=8'hA5.
  - tx is low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16.
  - is_transmitting is high for exactly 160 cycles.
  - A second transmit (8'h00) at cycle 50 has no effect.
- RX good frame: drive 8'h3C at 16 cycles/bit on rx.
  - One received pulse at 2+8+144 (±1) cycles after the start edge.
  - rx_byte=8'h3C, recv_error=0, is_receiving high throughout the frame.
- RX framing error: drive 8'h55 with stop bit = 0, then rx=1.
  - No received pulse, recv_error=1, rx_byte keeps its previous value.
  - A following good 8'h12 frame clears recv_error and sets rx_byte=8'h12.
- RX glitch and break:
  - A 4-cycle low pulse on rx gives no received pulse and no error, and is_receiving returns to 0.
  - A 400-cycle low break gives exactly one recv_error set and zero received pulses.
- Reset mid-operation: assert rst at cycle 70 of both a TX and an RX frame.
  - Next cycle: tx=1, is_transmitting=0, is_receiving=0, rx_byte=8'h00.
  - No received pulse follows.
- Default parameters (DIV=138): loopback tx to rx, send 8'hFF then 8'h00 back-to-back, each transmit issued once is_transmitting is low.
  - Both bytes are received correctly, with no recv_error.
